replay_ctrl: RTL and testbench

Parametrised recovery controller for the fault-tolerant core cluster. On a per-channel error flag it blocks instruction fetch and lets in-flight pipelines drain. It then walks the register file address range with a valid/ready handshake so a healthy copy can be written back. It retries on a new error during replay and latches a sticky failure once the retry budget is exhausted.

---
 rtl/replay_ctrl_if.sv | 12 +
 rtl/replay_ctrl.sv | 143 ++++++++++++++
 tb/tb_replay_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/replay_ctrl_if.sv
// Replay copy-path handshake: the controller presents a register address
// with valid, the register-file copy path accepts it with ready.
interface replay_ctrl_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;

  modport master (output valid, output addr, input ready);
  modport slave  (input valid, input addr, output ready);
endinterface

// File: rtl/replay_ctrl.sv
// Recovery controller for the redundant core cluster. A channel error blocks
// fetch, lets the pipelines drain, then walks the register file address range
// over the replay handshake so a healthy copy can be written back. A fresh
// error during replay restarts the walk until the retry budget runs out, at
// which point a sticky failure is latched until reset.
module replay_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_REG      = 2**ADDR_WIDTH,
  parameter int NUM_CH       = 3,
  parameter int DRAIN_CYCLES = 2,
  parameter int MAX_RETRY    = 3
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic [NUM_CH-1:0]   error_i,
  output logic                fetch_block_o,
  replay_ctrl_if.master       replay,
  output logic [NUM_CH-1:0]   faulty_ch_o,
  output logic [((MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1)-1:0] retry_cnt_o,
  output logic                done_o,
  output logic                fail_o
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Terminal values, pre-sized so every compare is width-matched.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_REG - 1);
  localparam logic [RETRY_W-1:0]    RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_REPLAY = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t                state_r;
  logic [DRAIN_W-1:0]    drain_cnt_r;
  logic                  valid_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  any_err_s;

  assign any_err_s    = |error_i;
  assign replay.valid = valid_r;
  assign replay.addr  = addr_r;

  // Recovery FSM; every output is a flop updated here.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      drain_cnt_r   <= {DRAIN_W{1'b0}};
      valid_r       <= 1'b0;
      addr_r        <= {ADDR_WIDTH{1'b0}};
      fetch_block_o <= 1'b0;
      faulty_ch_o   <= {NUM_CH{1'b0}};
      retry_cnt_o   <= {RETRY_W{1'b0}};
      done_o        <= 1'b0;
      fail_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_err_s) begin
            // New episode: previous fault record and retry count are replaced.
            faulty_ch_o   <= error_i;
            fetch_block_o <= 1'b1;
            drain_cnt_r   <= {DRAIN_W{1'b0}};
            retry_cnt_o   <= {RETRY_W{1'b0}};
            addr_r        <= {ADDR_WIDTH{1'b0}};
            if (DRAIN_CYCLES == 0) begin
              state_r <= ST_REPLAY;
              valid_r <= 1'b1;
            end else begin
              state_r <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          // Late errors only widen the fault record while draining.
          faulty_ch_o <= faulty_ch_o | error_i;
          if ((DRAIN_CYCLES == 0) || (drain_cnt_r == DRAIN_LAST)) begin
            state_r <= ST_REPLAY;
            valid_r <= 1'b1;
            addr_r  <= {ADDR_WIDTH{1'b0}};
          end else begin
            drain_cnt_r <= drain_cnt_r + DRAIN_W'(1'b1);
          end
        end

        ST_REPLAY: begin
          if (any_err_s) begin
            // An error beats a coincident handshake, including the last one.
            faulty_ch_o <= faulty_ch_o | error_i;
            valid_r     <= 1'b0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            drain_cnt_r <= {DRAIN_W{1'b0}};
            if (retry_cnt_o < RETRY_MAX) begin
              retry_cnt_o <= retry_cnt_o + RETRY_W'(1'b1);
              state_r     <= ST_DRAIN;
            end else begin
              fail_o  <= 1'b1;
              state_r <= ST_FAIL;
            end
          end else if (replay.ready) begin
            if (addr_r == LAST_ADDR) begin
              valid_r       <= 1'b0;
              addr_r        <= {ADDR_WIDTH{1'b0}};
              done_o        <= 1'b1;
              fetch_block_o <= 1'b0;
              state_r       <= ST_DONE;
            end else begin
              addr_r <= addr_r + ADDR_WIDTH'(1'b1);
            end
          end
        end

        ST_DONE: begin
          // Errors here are dropped; a persisting one restarts from IDLE.
          state_r <= ST_IDLE;
        end

        ST_FAIL: begin
          fetch_block_o <= 1'b1;
          fail_o        <= 1'b1;
          valid_r       <= 1'b0;
        end

        default: begin
          state_r       <= ST_IDLE;
          valid_r       <= 1'b0;
          addr_r        <= {ADDR_WIDTH{1'b0}};
          fetch_block_o <= 1'b0;
          fail_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_replay_ctrl.sv
// Self-checking bench for replay_ctrl: a scoreboard queue holds the addresses
// each replay pass must hand over, a monitor pops and compares on every
// accepted handshake, and directed sequences cover drain timing, backpressure,
// retry, exhaustion, reset and a short no-drain configuration.
module tb_replay_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [2:0] error_a = 3'b000;
  logic       fetch_a, done_a, fail_a;
  logic [2:0] faulty_a;
  logic [1:0] retry_a;

  logic [2:0] error_b = 3'b000;
  logic       fetch_b, done_b, fail_b;
  logic [2:0] faulty_b;
  logic [1:0] retry_b;

  int n_vec = 0;
  int n_err = 0;

  int         exp_q[$];
  logic [3:0] bp_pat = 4'b1001;

  logic       prev_stall = 1'b0;
  logic [4:0] prev_addr  = 5'd0;

  replay_ctrl_if #(.ADDR_WIDTH(5)) ifa ();
  replay_ctrl_if #(.ADDR_WIDTH(3)) ifb ();

  replay_ctrl dut_a (
    .clk(clk), .rst_i(rst), .error_i(error_a), .fetch_block_o(fetch_a),
    .replay(ifa.master), .faulty_ch_o(faulty_a), .retry_cnt_o(retry_a),
    .done_o(done_a), .fail_o(fail_a)
  );

  replay_ctrl #(.ADDR_WIDTH(3), .NUM_REG(5), .NUM_CH(3), .DRAIN_CYCLES(0), .MAX_RETRY(3)) dut_b (
    .clk(clk), .rst_i(rst), .error_i(error_b), .fetch_block_o(fetch_b),
    .replay(ifb.master), .faulty_ch_o(faulty_b), .retry_cnt_o(retry_b),
    .done_o(done_b), .fail_o(fail_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(k);
  endtask

  task automatic check_reset_a(input string tag);
    check_val({tag, "_a"}, {fetch_a, ifa.valid, ifa.addr, faulty_a, retry_a, done_a, fail_a}, 32'd0);
  endtask

  // Wait for a valid beat at the target address, then raise an error there.
  task automatic hit_addr(input int target, input logic [2:0] err);
    int n;
    n = 0;
    while (n < 200 && !(ifa.valid && (int'(ifa.addr) == target))) begin
      tick();
      n++;
    end
    check_val("reach_addr", {31'd0, (ifa.valid && (int'(ifa.addr) == target))}, 32'd1);
    error_a = err;
    tick();
    error_a = 3'b000;
  endtask

  task automatic wait_done(input int budget, input bit bp, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      ifa.ready = bp ? bp_pat[i % 4] : 1'b1;
      tick();
      cycles++;
      if (done_a) break;
    end
    ifa.ready = 1'b1;
    check_val("done_seen", {31'd0, done_a}, 32'd1);
  endtask

  // Scoreboard monitor: every accepted beat on DUT A must match the queue head,
  // and a stalled beat must hold its address into the next cycle.
  always @(negedge clk) begin
    if (!rst && prev_stall)
      check_val("stall_hold", {26'd0, ifa.valid, ifa.addr}, {26'd0, 1'b1, prev_addr});
    if (!rst && ifa.valid && ifa.ready && (error_a == 3'b000)) begin
      if (exp_q.size() == 0) check_val("unexpected_hs", {27'd0, ifa.addr}, 32'hFFFF_FFFF);
      else check_val("hs_addr", {27'd0, ifa.addr}, exp_q.pop_front());
    end
    prev_stall = !rst && ifa.valid && !ifa.ready && (error_a == 3'b000);
    prev_addr  = ifa.addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    ifa.ready = 1'b1;
    ifb.ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_reset_a("reset");
    check_val("reset_b", {fetch_b, ifb.valid, ifb.addr, faulty_b, retry_b, done_b, fail_b}, 32'd0);

    // Nominal episode, ready tied high.
    refill(32);
    error_a = 3'b010;
    tick();
    error_a = 3'b000;
    check_val("nom_block", {fetch_a, ifa.valid, faulty_a, retry_a}, {26'd0, 1'b1, 1'b0, 3'b010, 2'd0});
    tick();
    check_val("nom_drain", {31'd0, ifa.valid}, 32'd0);
    tick();
    check_val("nom_first", {26'd0, ifa.valid, ifa.addr}, {26'd0, 1'b1, 5'd0});
    wait_done(40, 1'b0, cyc);
    check_val("nom_cycles", cyc, 32'd32);
    check_val("nom_done", {fetch_a, ifa.valid, faulty_a, retry_a}, {26'd0, 1'b0, 1'b0, 3'b010, 2'd0});
    check_val("nom_left", exp_q.size(), 32'd0);
    tick();
    check_val("nom_pulse", {30'd0, done_a, fetch_a}, 32'd0);

    // Short configuration without drain.
    error_b = 3'b001;
    tick();
    error_b = 3'b000;
    check_val("b_first", {27'd0, fetch_b, ifb.valid, ifb.addr}, {27'd0, 1'b1, 1'b1, 3'd0});
    for (int k = 1; k < 5; k++) begin
      tick();
      check_val("b_addr", {28'd0, ifb.valid, ifb.addr}, {28'd0, 1'b1, 3'(k)});
    end
    tick();
    check_val("b_done", {29'd0, done_b, ifb.valid, fetch_b}, {29'd0, 1'b1, 1'b0, 1'b0});

    // Backpressure with ready pattern 1,0,0,1.
    refill(32);
    error_a = 3'b100;
    tick();
    error_a = 3'b000;
    wait_done(200, 1'b1, cyc);
    check_val("bp_left", exp_q.size(), 32'd0);
    tick();

    // Single retry: error on channel 2 at address 7.
    refill(32);
    error_a = 3'b001;
    tick();
    error_a = 3'b000;
    hit_addr(7, 3'b100);
    check_val("rt_drop", {26'd0, ifa.valid, ifa.addr}, 32'd0);
    check_val("rt_state", {27'd0, retry_a, faulty_a}, {27'd0, 2'd1, 3'b101});
    refill(32);
    tick();
    check_val("rt_drain", {31'd0, ifa.valid}, 32'd0);
    tick();
    check_val("rt_restart", {26'd0, ifa.valid, ifa.addr}, {26'd0, 1'b1, 5'd0});
    wait_done(40, 1'b0, cyc);
    check_val("rt_cycles", cyc, 32'd32);
    check_val("rt_final", {27'd0, retry_a, faulty_a}, {27'd0, 2'd1, 3'b101});
    tick();

    // Error coincident with the final handshake restarts instead of finishing.
    refill(32);
    error_a = 3'b010;
    tick();
    error_a = 3'b000;
    hit_addr(31, 3'b001);
    check_val("last_restart", {29'd0, done_a, ifa.valid, fetch_a}, {29'd0, 1'b0, 1'b0, 1'b1});
    check_val("last_retry", {30'd0, retry_a}, 32'd1);
    refill(32);
    wait_done(60, 1'b0, cyc);
    check_val("last_left", exp_q.size(), 32'd0);
    tick();

    // Retry exhaustion: four failing passes.
    refill(32);
    error_a = 3'b001;
    tick();
    error_a = 3'b000;
    for (int p = 0; p < 4; p++) begin
      hit_addr(5, 3'b100);
      if (p < 3) begin
        check_val("ex_retry", {29'd0, fail_a, retry_a}, {29'd0, 1'b0, 2'(p + 1)});
        refill(32);
      end
    end
    check_val("ex_fail", {fail_a, fetch_a, ifa.valid, retry_a, faulty_a}, {24'd0, 1'b1, 1'b1, 1'b0, 2'd3, 3'b101});
    exp_q.delete();
    error_a = 3'b111;
    for (int k = 0; k < 3; k++) tick();
    error_a = 3'b000;
    check_val("ex_sticky", {fail_a, fetch_a, ifa.valid, retry_a, faulty_a}, {24'd0, 1'b1, 1'b1, 1'b0, 2'd3, 3'b101});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_a("ex_reset");

    // Reset in the middle of a replay pass.
    refill(32);
    error_a = 3'b010;
    tick();
    error_a = 3'b000;
    cyc = 0;
    while (cyc < 100 && !(ifa.valid && ifa.addr == 5'd12)) begin
      tick();
      cyc++;
    end
    check_val("mid_reach", {26'd0, ifa.valid, ifa.addr}, {26'd0, 1'b1, 5'd12});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_reset_a("mid_reset");
    tick();
    check_reset_a("mid_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
